// File: rtl/axi_lite_test_m.sv
// AXI4-Lite master self-test sequencer.
// After a start pulse it writes C_NUM_REGS consecutive registers with
// seed+idx, reads each one back, and counts mismatches and non-OKAY
// responses. Only one transaction is ever outstanding.
//
// Handshake rule on every channel: a transfer happens on the rising edge
// where valid and ready are both high. A raised valid, with its address or
// data, stays unchanged until that edge and drops right after it. Ready
// never waits on valid.
module axi_lite_test_m #(
    parameter int C_M00_AXI_DATA_WIDTH = 32,
    parameter int C_M00_AXI_ADDR_WIDTH = 4,
    parameter int C_NUM_REGS           = 4,
    parameter int C_BASE_ADDR          = 0
) (
    input  logic                                m00_axi_aclk,
    input  logic                                m00_axi_aresetn,
    input  logic                                start,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     seed,
    output logic                                busy,
    output logic                                done,
    output logic                                error,
    output logic [7:0]                          err_count,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
    output logic [2:0]                          m00_axi_awprot,
    output logic                                m00_axi_awvalid,
    input  logic                                m00_axi_awready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
    output logic [C_M00_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
    output logic                                m00_axi_wvalid,
    input  logic                                m00_axi_wready,
    input  logic [1:0]                          m00_axi_bresp,
    input  logic                                m00_axi_bvalid,
    output logic                                m00_axi_bready,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
    output logic [2:0]                          m00_axi_arprot,
    output logic                                m00_axi_arvalid,
    input  logic                                m00_axi_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
    input  logic [1:0]                          m00_axi_rresp,
    input  logic                                m00_axi_rvalid,
    output logic                                m00_axi_rready
);

    localparam int DW    = C_M00_AXI_DATA_WIDTH;
    localparam int AW    = C_M00_AXI_ADDR_WIDTH;
    localparam int IDX_W = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_NUM_REGS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]       state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [DW-1:0]    seed_q;
    logic             is_last;
    logic             aw_complete;
    logic             w_complete;
    logic             rd_bad;

    // Register byte address for a given register index.
    function automatic logic [AW-1:0] addr_of(input logic [IDX_W-1:0] i);
        return AW'(C_BASE_ADDR + 4 * int'(i));
    endfunction

    // Saturating increment for the error counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    assign m00_axi_awprot = 3'b000;
    assign m00_axi_arprot = 3'b000;
    assign m00_axi_wstrb  = '1;

    // A write channel is finished once its valid has dropped, or it is
    // transferring on this edge.
    assign idx_nxt     = idx + IDX_W'(1);
    assign is_last     = (idx == LAST_IDX);
    assign aw_complete = !m00_axi_awvalid || m00_axi_awready;
    assign w_complete  = !m00_axi_wvalid  || m00_axi_wready;
    assign rd_bad      = (m00_axi_rdata != seed_q + DW'(idx)) || (m00_axi_rresp != 2'b00);

    // Sequencer: state, index, bus outputs and error bookkeeping.
    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state           <= S_IDLE;
            idx             <= '0;
            seed_q          <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            err_count       <= 8'd0;
            m00_axi_awaddr  <= '0;
            m00_axi_awvalid <= 1'b0;
            m00_axi_wdata   <= '0;
            m00_axi_wvalid  <= 1'b0;
            m00_axi_bready  <= 1'b0;
            m00_axi_araddr  <= '0;
            m00_axi_arvalid <= 1'b0;
            m00_axi_rready  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        seed_q          <= seed;
                        error           <= 1'b0;
                        err_count       <= 8'd0;
                        busy            <= 1'b1;
                        idx             <= '0;
                        m00_axi_awaddr  <= addr_of('0);
                        m00_axi_wdata   <= seed;
                        m00_axi_awvalid <= 1'b1;
                        m00_axi_wvalid  <= 1'b1;
                        state           <= S_WR;
                    end
                end
                S_WR: begin
                    if (m00_axi_awvalid && m00_axi_awready) begin
                        m00_axi_awvalid <= 1'b0;
                    end
                    if (m00_axi_wvalid && m00_axi_wready) begin
                        m00_axi_wvalid <= 1'b0;
                    end
                    if (aw_complete && w_complete) begin
                        m00_axi_bready <= 1'b1;
                        state          <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (m00_axi_bvalid && m00_axi_bready) begin
                        m00_axi_bready <= 1'b0;
                        if (m00_axi_bresp != 2'b00) begin
                            err_count <= sat_inc(err_count);
                            error     <= 1'b1;
                        end
                        if (is_last) begin
                            idx             <= '0;
                            m00_axi_araddr  <= addr_of('0);
                            m00_axi_arvalid <= 1'b1;
                            state           <= S_RD_ADDR;
                        end else begin
                            idx             <= idx_nxt;
                            m00_axi_awaddr  <= addr_of(idx_nxt);
                            m00_axi_wdata   <= seed_q + DW'(idx_nxt);
                            m00_axi_awvalid <= 1'b1;
                            m00_axi_wvalid  <= 1'b1;
                            state           <= S_WR;
                        end
                    end
                end
                S_RD_ADDR: begin
                    if (m00_axi_arvalid && m00_axi_arready) begin
                        m00_axi_arvalid <= 1'b0;
                        m00_axi_rready  <= 1'b1;
                        state           <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (m00_axi_rvalid && m00_axi_rready) begin
                        m00_axi_rready <= 1'b0;
                        if (rd_bad) begin
                            err_count <= sat_inc(err_count);
                            error     <= 1'b1;
                        end
                        if (is_last) begin
                            idx   <= '0;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            idx             <= idx_nxt;
                            m00_axi_araddr  <= addr_of(idx_nxt);
                            m00_axi_arvalid <= 1'b1;
                            state           <= S_RD_ADDR;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_test_m.sv
// Bench for axi_lite_test_m: a configurable AXI-lite slave stub, a per-cycle
// checker against a transaction-level model, and directed scenarios.
module tb_axi_lite_test_m;

    localparam int N = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] seed;
    logic        busy, done, error;
    logic [7:0]  err_count;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    axi_lite_test_m dut (
        .m00_axi_aclk(clk), .m00_axi_aresetn(rst_n),
        .start(start), .seed(seed),
        .busy(busy), .done(done), .error(error), .err_count(err_count),
        .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot),
        .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
        .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
        .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
        .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
        .m00_axi_araddr(araddr), .m00_axi_arprot(arprot),
        .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
        .m00_axi_rdata(rdata), .m00_axi_rresp(rresp),
        .m00_axi_rvalid(rvalid), .m00_axi_rready(rready)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- slave stub ----------------
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [3:0]  bresp_err_mask = 4'b0, rflip_mask = 4'b0, rresp_err_mask = 4'b0;
    logic [31:0] regs [N];
    logic        hs_aw, hs_w, hs_b, hs_ar, hs_r;
    logic        aw_got, w_got, ar_got;
    logic [3:0]  aw_addr_l, ar_addr_l;
    logic [31:0] w_data_l;
    int          aw_cnt, w_cnt, ar_cnt;

    task automatic slave_clear();
        awready = 0; wready = 0; arready = 0;
        bvalid = 0; bresp = 2'b00; rvalid = 0; rresp = 2'b00; rdata = '0;
        hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        aw_addr_l = '0; ar_addr_l = '0; w_data_l = '0;
    endtask

    // The slave acts at each falling edge; flags hs_* name the transfers
    // that the following rising edge will complete.
    initial begin
        for (int i = 0; i < N; i++) regs[i] = '0;
        slave_clear();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                slave_clear();
            end else begin
                if (hs_b) bvalid = 0;
                if (hs_r) rvalid = 0;
                if (hs_aw) aw_got = 1;
                if (hs_w) w_got = 1;
                if (hs_ar) ar_got = 1;
                if (aw_got && w_got) begin
                    regs[aw_addr_l[3:2]] = w_data_l;
                    bresp  = bresp_err_mask[aw_addr_l[3:2]] ? 2'b10 : 2'b00;
                    bvalid = 1;
                    aw_got = 0;
                    w_got  = 0;
                end
                if (ar_got) begin
                    rdata  = regs[ar_addr_l[3:2]] ^ {31'd0, rflip_mask[ar_addr_l[3:2]]};
                    rresp  = rresp_err_mask[ar_addr_l[3:2]] ? 2'b10 : 2'b00;
                    rvalid = 1;
                    ar_got = 0;
                end
                awready = 0;
                if (awvalid) begin
                    if (aw_cnt >= aw_delay) begin awready = 1; aw_cnt = 0; end
                    else aw_cnt++;
                end
                wready = 0;
                if (wvalid) begin
                    if (w_cnt >= w_delay) begin wready = 1; w_cnt = 0; end
                    else w_cnt++;
                end
                arready = 0;
                if (arvalid) begin
                    if (ar_cnt >= ar_delay) begin arready = 1; ar_cnt = 0; end
                    else ar_cnt++;
                end
                hs_aw = awvalid & awready;
                hs_w  = wvalid & wready;
                hs_ar = arvalid & arready;
                hs_b  = bvalid & bready;
                hs_r  = rvalid & rready;
                if (hs_aw) aw_addr_l = awaddr;
                if (hs_w)  w_data_l  = wdata;
                if (hs_ar) ar_addr_l = araddr;
            end
        end
    end

    // ---------------- model + per-cycle compare ----------------
    logic [31:0] exp_aw_q[$], exp_w_q[$], exp_ar_q[$], exp_r_q[$];
    bit          active_exp, done_exp, done_next, active_next;
    logic [7:0]  err_exp;
    int          reads_left;
    int          wr_n = 0, rd_n = 0, b_n = 0, done_n = 0;
    int          aw_len, w_len, ar_len;
    logic        prev_awv, prev_awhs, prev_wv, prev_whs, prev_arv, prev_arhs;
    logic [3:0]  prev_awaddr, prev_araddr;
    logic [31:0] prev_wdata;

    task automatic model_clear();
        exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete(); exp_r_q.delete();
        active_exp = 0; done_exp = 0; err_exp = 0; reads_left = 0;
        aw_len = 0; w_len = 0; ar_len = 0;
        prev_awv = 0; prev_awhs = 0; prev_wv = 0; prev_whs = 0; prev_arv = 0; prev_arhs = 0;
        prev_awaddr = 0; prev_araddr = 0; prev_wdata = 0;
    endtask

    function automatic logic [7:0] sat(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    initial begin
        model_clear();
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                model_clear();
            end else begin
                check("busy", busy, active_exp);
                check("done", done, done_exp);
                if (done) done_n++;
                check("err_count", err_count, err_exp);
                check("error", error, err_exp != 0);
                check("prot_strb", {awprot, arprot, wstrb}, {3'b000, 3'b000, 4'hF});
                if (prev_awv && !prev_awhs) check("aw_hold", {awvalid, awaddr}, {1'b1, prev_awaddr});
                if (prev_wv && !prev_whs)   check("w_hold", {wvalid, wdata}, {1'b1, prev_wdata});
                if (prev_arv && !prev_arhs) check("ar_hold", {arvalid, araddr}, {1'b1, prev_araddr});
                if (prev_awhs) check("aw_drop", awvalid, 1'b0);
                if (prev_whs)  check("w_drop", wvalid, 1'b0);
                if (prev_arhs) check("ar_drop", arvalid, 1'b0);
                // No read traffic while a write is in flight and vice versa.
                if (awvalid || wvalid || bready) check("no_overlap", {arvalid, rready}, 2'b00);

                done_next   = 0;
                active_next = active_exp;
                if (awvalid) aw_len++;
                if (wvalid)  w_len++;
                if (arvalid) ar_len++;
                if (awvalid && awready) begin
                    wr_n++;
                    check("aw_wait", aw_len, aw_delay + 1);
                    aw_len = 0;
                    if (exp_aw_q.size() == 0) check("aw_extra", 1, 0);
                    else check("awaddr", awaddr, exp_aw_q.pop_front());
                end
                if (wvalid && wready) begin
                    check("w_wait", w_len, w_delay + 1);
                    w_len = 0;
                    if (exp_w_q.size() == 0) check("w_extra", 1, 0);
                    else check("wdata", wdata, exp_w_q.pop_front());
                end
                if (bvalid && bready) begin
                    b_n++;
                    if (bresp != 2'b00) err_exp = sat(err_exp);
                end
                if (arvalid && arready) begin
                    ar_len = 0;
                    if (exp_ar_q.size() == 0) check("ar_extra", 1, 0);
                    else check("araddr", araddr, exp_ar_q.pop_front());
                end
                if (rvalid && rready) begin
                    rd_n++;
                    if (exp_r_q.size() == 0) begin
                        check("r_extra", 1, 0);
                    end else if (rdata != exp_r_q.pop_front() || rresp != 2'b00) begin
                        err_exp = sat(err_exp);
                    end
                    reads_left--;
                    if (reads_left == 0) begin
                        done_next   = 1;
                        active_next = 0;
                    end
                end
                if (start && !active_exp && !done_exp) begin
                    active_next = 1;
                    err_exp     = 0;
                    reads_left  = N;
                    for (int i = 0; i < N; i++) begin
                        exp_aw_q.push_back(32'(4 * i));
                        exp_w_q.push_back(seed + 32'(i));
                        exp_ar_q.push_back(32'(4 * i));
                        exp_r_q.push_back(seed + 32'(i));
                    end
                end
                done_exp   = done_next;
                active_exp = active_next;
                prev_awv = awvalid; prev_awhs = awvalid && awready; prev_awaddr = awaddr;
                prev_wv  = wvalid;  prev_whs  = wvalid && wready;   prev_wdata  = wdata;
                prev_arv = arvalid; prev_arhs = arvalid && arready; prev_araddr = araddr;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input logic [31:0] s);
        @(negedge clk);
        seed  = s;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic run(input string tag, input logic [31:0] s, input bit extra_start);
        int  wr0, rd0, b0, d0;
        bit  seen;
        wr0 = wr_n; rd0 = rd_n; b0 = b_n; d0 = done_n;
        seen = 0;
        pulse_start(s);
        if (extra_start) begin
            repeat (5) @(negedge clk);
            pulse_start(32'hDEAD0000);
        end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            #2;
            if (done) begin seen = 1; break; end
        end
        if (!seen) check({tag, "_timeout"}, 0, 1);
        repeat (4) @(negedge clk);
        #2;
        check({tag, "_writes"}, wr_n - wr0, N);
        check({tag, "_reads"}, rd_n - rd0, N);
        check({tag, "_bresps"}, b_n - b0, N);
        check({tag, "_dones"}, done_n - d0, 1);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_queues"}, exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_r_q.size(), 0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        bit seen;
        rst_n = 0;
        start = 0;
        seed  = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_ctl", {busy, done, error, err_count}, 11'd0);
        check("reset_bus", {awvalid, wvalid, bready, arvalid, rready, awaddr, araddr, wdata}, 45'd0);
        @(negedge clk);
        #3;
        rst_n = 1;

        // Clean run against the slave, zero wait states.
        run("basic", 32'h10000000, 0);
        check("basic_reg0", regs[0], 32'h10000000);
        check("basic_reg1", regs[1], 32'h10000001);
        check("basic_reg2", regs[2], 32'h10000002);
        check("basic_reg3", regs[3], 32'h10000003);
        check("basic_err", {error, err_count}, 9'd0);

        // Data wraps through zero.
        run("wrap", 32'hFFFFFFFE, 0);
        check("wrap_reg0", regs[0], 32'hFFFFFFFE);
        check("wrap_reg1", regs[1], 32'hFFFFFFFF);
        check("wrap_reg2", regs[2], 32'h00000000);
        check("wrap_reg3", regs[3], 32'h00000001);
        check("wrap_err", {error, err_count}, 9'd0);

        // Slow awready, immediate wready; then slow W and AR channels.
        aw_delay = 3;
        run("awslow", 32'hA5A50000, 0);
        aw_delay = 0; w_delay = 2; ar_delay = 2;
        run("wslow", 32'h0BADF00D, 0);
        w_delay = 0; ar_delay = 0;

        // Bad write response on reg 0 and corrupted read data on reg 2.
        bresp_err_mask = 4'b0001;
        rflip_mask     = 4'b0100;
        run("errs", 32'h12340000, 0);
        check("errs_count", err_count, 8'd2);
        check("errs_flag", error, 1'b1);
        // Read data and response both bad on one register counts once.
        bresp_err_mask = 4'b0000;
        rflip_mask     = 4'b1000;
        rresp_err_mask = 4'b1000;
        run("both", 32'h55550000, 0);
        check("both_count", err_count, 8'd1);
        rflip_mask     = 4'b0000;
        rresp_err_mask = 4'b0000;
        run("clean", 32'h12340000, 0);
        check("clean_count", {error, err_count}, 9'd0);

        // Second start while busy is ignored.
        run("restart", 32'h00C0FFEE, 1);
        check("restart_reg3", regs[3], 32'h00C0FFF1);

        // Reset while waiting for read data.
        pulse_start(32'h77770000);
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            #2;
            if (rready) begin seen = 1; break; end
        end
        if (!seen) check("rd_data_timeout", 0, 1);
        #1;
        rst_n = 0;
        #1;
        check("midreset_bus", {awvalid, wvalid, bready, arvalid, rready}, 5'd0);
        check("midreset_ctl", {busy, done, error, err_count}, 11'd0);
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1;
        run("after_reset", 32'h31415926, 0);
        check("after_reset_reg1", regs[1], 32'h31415927);
        check("after_reset_err", {error, err_count}, 9'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
